multicycle_control_fsm: RTL

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/imm_src_decoder.sv | 20 ++
 rtl/multicycle_control_fsm.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multicycle control FSM
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// rtl/imm_src_decoder.sv - immediate format select, purely a function of the opcode
module imm_src_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_I, OP_LW: o_imm_src = IMM_I;
      OP_SW:       o_imm_src = IMM_S;
      OP_BEQ:      o_imm_src = IMM_B;
      OP_JAL:      o_imm_src = IMM_J;
      default:     o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for a multicycle RV32 subset datapath
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit STALL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_op
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_ready;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;

  assign w_ready = STALL_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_adr_src    = ADR_PC;
    w_result_src = RES_ALUOUT;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_REG;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = w_ready;
        w_pc_update  = w_ready;
        if (w_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_I:         w_next_state = S_EXECI;
          OP_JAL:       w_next_state = S_JAL;
          OP_BEQ:       w_next_state = S_BEQ;
          default: begin
            w_next_state = S_FETCH;
            w_illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = SRCA_REG;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = ADR_RESULT;
        if (w_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      // The write strobe stays up for the whole access, not just the completing cycle.
      S_MEMWRITE: begin
        w_adr_src   = ADR_RESULT;
        w_mem_write = 1'b1;
        if (w_ready) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a  = SRCA_REG;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a  = SRCA_REG;
        w_alu_src_b  = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a  = SRCA_OLDPC;
        w_alu_src_b  = SRCB_FOUR;
        w_pc_update  = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_BEQ: begin
        w_alu_src_a  = SRCA_REG;
        w_alu_op     = ALUOP_SUB;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Enables are gated by rst so nothing fires while the asynchronous reset is held.
  assign PCWrite    = ~rst & (w_pc_update | (w_branch & zero));
  assign MemWrite   = ~rst & w_mem_write;
  assign IRWrite    = ~rst & w_ir_write;
  assign RegWrite   = ~rst & w_reg_write;
  assign illegal_op = ~rst & w_illegal;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_alu_src_a;
  assign ALUSrcB    = w_alu_src_b;
  assign ALUOp      = w_alu_op;

  imm_src_decoder u_imm_src_decoder (
    .i_op      (op),
    .o_imm_src (ImmSrc)
  );

endmodule
